perm_slice_controller: RTL
==========================

// Module: perm_slice_controller
// PURPOSE
//   Control FSM driving the slice-index counter (6-bit, count_en/cout) of the permutation datapath.
//   Sweeps all 64 slices. Per slice: read 5 rows, compute 1 cycle, write 5 rows, then advance the slice index.
//   Consumes the counter's terminal carry to detect the last slice. Start/ready/done handshake to the top level.
// PARAMETERS
//   ROWS    5  rows per slice; sets the read and write phase length
//   ROW_W   3  width of row_idx; must satisfy 2**ROW_W >= ROWS
//   ROUNDS  1  full sweeps per start; used only when PERM_MULTI_ROUND_EN is defined
// PORTS
//   clk        in   1      clock, rising edge
//   reset      in   1      asynchronous, active-high
//   start      in   1      request a permutation; sampled only in IDLE
//   abort      in   1      synchronous abort; return to IDLE
//   ready      out  1      high only in IDLE
//   done       out  1      one-cycle pulse when the sweep completes
//   cnt_clr    out  1      clear pulse to the slice counter (registered)
//   z_count_en out  1      enable to the slice counter
//   z_cout     in   1      slice counter carry: z_count_en & (index==63)
//   row_idx    out  ROW_W  current row, 0..ROWS-1
//   mem_rd     out  1      state-memory read strobe
//   calc_en    out  1      datapath compute strobe
//   mem_wr     out  1      state-memory write strobe
//   round_idx  out  8      current round; present only with PERM_MULTI_ROUND_EN
// BEHAVIOUR
//   Reset: state=IDLE, ready=1, row_idx=0, round_idx=0; all other outputs 0.
//   States and transitions:
//     IDLE -> INIT on start. start outside IDLE is ignored.
//     INIT: cnt_clr=1 for 1 cycle -> READ.
//     READ: mem_rd=1, row_idx 0..ROWS-1, one row per cycle -> CALC after row ROWS-1.
//     CALC: calc_en=1 for 1 cycle; row_idx=0 -> WRITE.
//     WRITE: mem_wr=1, row_idx 0..ROWS-1 -> NEXT after row ROWS-1.
//     NEXT: z_count_en=1 for 1 cycle. z_cout=1 -> DONE (counter wraps to 0); else -> READ.
//     DONE: done=1 for 1 cycle -> IDLE.
//   Strobes are Moore outputs decoded from state. At most one of mem_rd, calc_en, mem_wr is high.
//   row_idx changes only in READ/WRITE. It wraps ROWS-1 -> 0 at each phase end and never reaches ROWS.
//   Latency with ROWS=5: 1 INIT + 64*12 + 1 DONE. done is high in cycle 770 after the edge that samples start.
//   z_count_en is asserted exactly 64 times per sweep. z_cout outside NEXT is ignored.
//   abort in any non-IDLE state -> IDLE next cycle. No done pulse. cnt_clr pulses in that cycle.
//   abort has priority over every other transition. In IDLE, abort and start together: abort wins.
//   Reset mid-sweep: immediate IDLE. The slice counter shares reset.
// CONFIGURATION
//   PERM_MULTI_ROUND_EN defined: round_idx port and an 8-bit round register exist.
//     NEXT with z_cout=1 and round_idx<ROUNDS-1: round_idx+1 -> READ, with no new cnt_clr.
//     The counter has already wrapped to 0 at that point.
//     Last round -> DONE. round_idx clears in INIT and on abort.
//     Latency = 1 + ROUNDS*768 + 1.
//   Not defined: single sweep; ROUNDS ignored; port absent.
// STRUCTURE
//   perm_pkg: state enum (IDLE, INIT, READ, CALC, WRITE, NEXT, DONE), SLICE_W=6, SLICES=64, default ROWS.
//   Sub-module perm_row_counter: mod-ROWS up-counter with en/clr and a last flag (row_idx==ROWS-1).
//   Instantiated once and reused for the read and write phases.
// TESTING
//   1. Reset -> ready=1, every strobe=0.
//      Release, start pulse -> cnt_clr at +1; done exactly 770 cycles after start.
//   2. Count per sweep: 320 mem_rd, 64 calc_en, 320 mem_wr, 64 z_count_en, 1 cnt_clr.
//      Counter value is 0 after done.
//   3. row_idx sequence in every READ and WRITE phase is 0,1,2,3,4. Never 5-7.
//   4. abort in WRITE of slice 10 -> IDLE next cycle, cnt_clr=1, no done.
//      A new start then completes in 770 cycles.
//   5. start held high during a sweep -> ignored.
//      Held through DONE -> second sweep begins right after IDLE.
//      Async reset at slice 30 -> IDLE immediately.
//   6. PERM_MULTI_ROUND_EN, ROUNDS=3 -> round_idx 0,1,2; single cnt_clr; done at cycle 2306.

Source files
------------

// File: rtl/perm_pkg.sv
// ---------------------------------------------------------------------------
// perm_pkg
//   Shared types and constants for the permutation slice controller.
//   - perm_state_e : controller FSM states
//   - SLICE_W/SLICES : slice-index counter geometry (6 bits, 64 slices)
//   - DEF_ROWS/DEF_ROW_W : default rows per slice and row-index width
//   Optional feature macro used by the files that import this package:
//   PERM_MULTI_ROUND_EN (multiple full sweeps per start).
// ---------------------------------------------------------------------------
package perm_pkg;

   localparam int SLICE_W   = 6;
   localparam int SLICES    = 64;
   localparam int DEF_ROWS  = 5;
   localparam int DEF_ROW_W = 3;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      INIT  = 3'd1,
      READ  = 3'd2,
      CALC  = 3'd3,
      WRITE = 3'd4,
      NEXT  = 3'd5,
      DONE  = 3'd6
   } perm_state_e;

endpackage

// File: rtl/perm_slice_controller_if.sv
// ---------------------------------------------------------------------------
// perm_slice_controller_if
//   Bundles the handshake and datapath-control signals of the slice
//   controller.
//   master modport (controller side):
//     in : start, abort, z_cout
//     out: ready, done, cnt_clr, z_count_en, row_idx, mem_rd, calc_en,
//          mem_wr, round_idx (only with PERM_MULTI_ROUND_EN)
//   slave modport: the same signals seen from the top level / datapath.
//   Macro PERM_MULTI_ROUND_EN adds the 8-bit round_idx signal.
// ---------------------------------------------------------------------------
interface perm_slice_controller_if
   import perm_pkg::*;
#(
   parameter int ROW_W = DEF_ROW_W
);
   logic             start;
   logic             abort;
   logic             ready;
   logic             done;
   logic             cnt_clr;
   logic             z_count_en;
   logic             z_cout;
   logic [ROW_W-1:0] row_idx;
   logic             mem_rd;
   logic             calc_en;
   logic             mem_wr;
`ifdef PERM_MULTI_ROUND_EN
   logic [7:0]       round_idx;

   modport master (
      input  start, abort, z_cout,
      output ready, done, cnt_clr, z_count_en, row_idx,
             mem_rd, calc_en, mem_wr, round_idx
   );

   modport slave (
      output start, abort, z_cout,
      input  ready, done, cnt_clr, z_count_en, row_idx,
             mem_rd, calc_en, mem_wr, round_idx
   );
`else
   modport master (
      input  start, abort, z_cout,
      output ready, done, cnt_clr, z_count_en, row_idx,
             mem_rd, calc_en, mem_wr
   );

   modport slave (
      output start, abort, z_cout,
      input  ready, done, cnt_clr, z_count_en, row_idx,
             mem_rd, calc_en, mem_wr
   );
`endif
endinterface

// File: rtl/perm_row_counter.sv
// ---------------------------------------------------------------------------
// perm_row_counter
//   Mod-ROWS up-counter shared by the READ and WRITE phases.
//   Ports:
//     clk    in  clock, rising edge
//     reset  in  asynchronous, active-high
//     en_i   in  advance one row
//     clr_i  in  synchronous clear (wins over en_i)
//     idx_o  out current row, 0..ROWS-1
//     last_o out idx_o == ROWS-1
// ---------------------------------------------------------------------------
module perm_row_counter
   import perm_pkg::*;
#(
   parameter int ROWS  = DEF_ROWS,
   parameter int ROW_W = DEF_ROW_W
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en_i,
   input  logic             clr_i,
   output logic [ROW_W-1:0] idx_o,
   output logic             last_o
);

   localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);

   if ((2 ** ROW_W) < ROWS) begin : g_bad_row_w
      $error("ROW_W too narrow for ROWS");
   end

   logic [ROW_W-1:0] idx_q;

   assign last_o = (idx_q == LAST_ROW);
   assign idx_o  = idx_q;

   // NOTE: state registers use non-blocking assignments so every flop samples
   // pre-edge values; blocking here would create order-dependent races.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         idx_q <= '0;
      end else if (clr_i) begin
         idx_q <= '0;
      end else if (en_i) begin
         // Wrap at ROWS-1 so the index never reaches ROWS.
         idx_q <= last_o ? '0 : idx_q + ROW_W'(1);
      end
   end

endmodule

// File: rtl/perm_slice_controller.sv
// ---------------------------------------------------------------------------
// perm_slice_controller
//   Control FSM for the permutation datapath. Sweeps all 64 slices; per slice
//   it reads ROWS rows, computes one cycle, writes ROWS rows, then advances the
//   external 6-bit slice counter. The counter's terminal carry (z_cout) marks
//   the last slice.
//   Ports:
//     clk    in  clock, rising edge
//     reset  in  asynchronous, active-high (shared with the slice counter)
//     bus    perm_slice_controller_if.master:
//            start/abort/z_cout in; ready/done/cnt_clr/z_count_en/row_idx/
//            mem_rd/calc_en/mem_wr out (+ round_idx with the macro below)
//   Macro PERM_MULTI_ROUND_EN: repeat the sweep ROUNDS times per start with an
//   8-bit round register on round_idx. Undefined: single sweep, ROUNDS unused.
// ---------------------------------------------------------------------------
module perm_slice_controller
   import perm_pkg::*;
#(
   parameter int ROWS   = DEF_ROWS,
   parameter int ROW_W  = DEF_ROW_W,
   parameter int ROUNDS = 1
) (
   input  logic                           clk,
   input  logic                           reset,
   perm_slice_controller_if.master        bus
);

   if ((ROUNDS < 1) || (ROUNDS > 256)) begin : g_bad_rounds
      $error("ROUNDS must be in 1..256");
   end

   perm_state_e      state_q, state_d;
   logic             cnt_clr_q, cnt_clr_d;
   logic             aborting;
   logic             more_rounds;
   logic             row_en, row_clr, row_last;
   logic [ROW_W-1:0] row_idx;

   // Abort only acts outside IDLE; in IDLE it merely blocks start.
   assign aborting = bus.abort && (state_q != IDLE);

   perm_row_counter #(
      .ROWS  (ROWS),
      .ROW_W (ROW_W)
   ) u_row_counter (
      .clk    (clk),
      .reset  (reset),
      .en_i   (row_en),
      .clr_i  (row_clr),
      .idx_o  (row_idx),
      .last_o (row_last)
   );

`ifdef PERM_MULTI_ROUND_EN
   localparam logic [7:0] LAST_ROUND = 8'(ROUNDS - 1);

   logic [7:0] round_q, round_d;

   assign more_rounds = (round_q < LAST_ROUND);

   always_comb begin
      round_d = round_q;
      if (aborting || (state_d == INIT)) begin
         round_d = '0;
      end else if ((state_q == NEXT) && bus.z_cout && more_rounds) begin
         // Counter has already wrapped to 0; the next round reuses it as is.
         round_d = round_q + 8'd1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         round_q <= '0;
      end else begin
         round_q <= round_d;
      end
   end

   assign bus.round_idx = round_q;
`else
   assign more_rounds = 1'b0;
`endif

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         cnt_clr_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_clr_q <= cnt_clr_d;
      end
   end

   // Next-state logic; abort overrides every other transition.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path
      // leaves it unassigned, which would infer a latch.
      state_d = state_q;
      if (aborting) begin
         state_d = IDLE;
      end else begin
         unique case (state_q)
            IDLE:    if (bus.start && !bus.abort) state_d = INIT;
            INIT:    state_d = READ;
            READ:    if (row_last) state_d = CALC;
            CALC:    state_d = WRITE;
            WRITE:   if (row_last) state_d = NEXT;
            NEXT:    state_d = (bus.z_cout && !more_rounds) ? DONE : READ;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   // Counter clear is registered: high in INIT and in the IDLE cycle after
   // an abort.
   assign cnt_clr_d = (state_d == INIT) || aborting;

   // Moore outputs decoded from the current state.
   always_comb begin
      bus.ready      = 1'b0;
      bus.done       = 1'b0;
      bus.z_count_en = 1'b0;
      bus.mem_rd     = 1'b0;
      bus.calc_en    = 1'b0;
      bus.mem_wr     = 1'b0;
      row_en         = 1'b0;
      unique case (state_q)
         IDLE:  bus.ready      = 1'b1;
         READ:  begin bus.mem_rd = 1'b1; row_en = 1'b1; end
         CALC:  bus.calc_en    = 1'b1;
         WRITE: begin bus.mem_wr = 1'b1; row_en = 1'b1; end
         NEXT:  bus.z_count_en = 1'b1;
         DONE:  bus.done       = 1'b1;
         default: ;
      endcase
   end

   assign row_clr     = aborting;
   assign bus.row_idx = row_idx;
   assign bus.cnt_clr = cnt_clr_q;

endmodule
